// File: rtl/crc_seq_ctrl.sv
// Sequencer for a serial 8-bit CRC LFSR core: takes a parallel word, clears the core,
// shifts the word in LSB-first, collects the serial CRC bits and returns them in parallel.
module crc_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CRC_WIDTH  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN_Data,
  input  logic                  IN_Valid,
  output logic                  IN_Ready,
  output logic [CRC_WIDTH-1:0]  OUT_CRC,
  output logic                  OUT_Err,
  output logic                  OUT_Valid,
  input  logic                  OUT_Ready,
  output logic                  CRC_RST_n,
  output logic                  CRC_Active,
  output logic                  CRC_Data,
  input  logic                  CRC_Valid,
  input  logic                  CRC_Bit
);

  // state   | meaning
  // IDLE    | waiting for an input word
  // CLR     | core held in reset for one cycle
  // SHIFT   | data word streamed into the core LSB-first
  // COLLECT | serial CRC bits captured, idle-cycle timer running
  // DONE    | result presented until the consumer accepts it

  localparam int MAX_A = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
  localparam int MAX_V = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
  localparam int CNT_W = $clog2(MAX_V) + 1;

  localparam logic [CNT_W-1:0] SHIFT_LAST   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] COLLECT_LAST = CNT_W'(CRC_WIDTH - 1);
  localparam logic [CNT_W-1:0] TIMER_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d;
  logic                  err_q, err_d;
  logic                  in_ready_q, out_valid_q, crc_rst_n_q, crc_active_q, crc_data_q;
  logic [CRC_WIDTH-1:0]  bit_mask;

  assign bit_mask = CRC_WIDTH'(1) << cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    data_d  = data_q;
    crc_d   = crc_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (IN_Valid && in_ready_q) begin
          data_d  = IN_Data;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        crc_d   = '0;
        err_d   = 1'b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // The latch is shifted so the next serial bit always sits at bit 0.
        data_d = data_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = '0;
          timer_d = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (CRC_Valid) begin
          crc_d   = (crc_q & ~bit_mask) | (CRC_Bit ? bit_mask : '0);
          cnt_d   = cnt_q + 1'b1;
          timer_d = '0;
          if (cnt_q == COLLECT_LAST) state_d = S_DONE;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        if (OUT_Ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      data_q       <= '0;
      crc_q        <= '0;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      crc_rst_n_q  <= 1'b0;
      crc_active_q <= 1'b0;
      crc_data_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      data_q       <= data_d;
      crc_q        <= crc_d;
      err_q        <= err_d;
      in_ready_q   <= (state_d == S_IDLE);
      out_valid_q  <= (state_d == S_DONE);
      crc_rst_n_q  <= (state_d != S_CLR);
      crc_active_q <= (state_d == S_SHIFT);
      crc_data_q   <= (state_d == S_SHIFT) && data_d[0];
    end
  end

  assign IN_Ready   = in_ready_q;
  assign OUT_Valid  = out_valid_q;
  assign OUT_CRC    = crc_q;
  assign OUT_Err    = err_q;
  assign CRC_RST_n  = crc_rst_n_q;
  assign CRC_Active = crc_active_q;
  assign CRC_Data   = crc_data_q;

endmodule

// File: tb/tb_crc_seq_ctrl.sv
// Self-checking bench for crc_seq_ctrl: vector table, hand-written corner sequences and
// randomized transactions, with a behavioural CRC core stub.
`timescale 1ns/1ps
module tb_crc_seq_ctrl;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] IN_Data = '0;
  logic          IN_Valid = 1'b0;
  logic          IN_Ready;
  logic [CW-1:0] OUT_CRC;
  logic          OUT_Err;
  logic          OUT_Valid;
  logic          OUT_Ready = 1'b0;
  logic          CRC_RST_n;
  logic          CRC_Active;
  logic          CRC_Data;
  logic          CRC_Valid = 1'b0;
  logic          CRC_Bit = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  crc_seq_ctrl #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .IN_Data(IN_Data), .IN_Valid(IN_Valid), .IN_Ready(IN_Ready),
    .OUT_CRC(OUT_CRC), .OUT_Err(OUT_Err), .OUT_Valid(OUT_Valid), .OUT_Ready(OUT_Ready),
    .CRC_RST_n(CRC_RST_n), .CRC_Active(CRC_Active), .CRC_Data(CRC_Data),
    .CRC_Valid(CRC_Valid), .CRC_Bit(CRC_Bit)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Core stub: records Data on Active cycles, counts reset cycles, and after the shift
  // phase streams the programmed (valid, bit) pattern one entry per cycle.
  logic prog_v [0:63];
  logic prog_b [0:63];
  logic shifted [0:15];
  int   nshift = 0;
  int   nclr = 0;
  int   idx = 0;
  bit   run = 0;

  always @(negedge CLK) begin
    if (CRC_RST_n !== 1'b1) begin
      nclr++;
      run = 0;
      CRC_Valid = 1'b0;
      CRC_Bit = 1'b0;
    end else if (CRC_Active) begin
      if (nshift < 16) shifted[nshift] = CRC_Data;
      nshift++;
      run = 1;
      idx = 0;
      CRC_Valid = 1'b0;
    end else if (run && idx < 64) begin
      CRC_Valid = prog_v[idx];
      CRC_Bit = prog_b[idx];
      idx++;
    end else begin
      CRC_Valid = 1'b0;
    end
  end

  task automatic program_stub(input int k, input int nbits, input logic [CW-1:0] crc);
    logic [CW-1:0] c;
    c = crc;
    for (int i = 0; i < 64; i++) begin
      prog_v[i] = 1'b0;
      prog_b[i] = 1'($urandom_range(0, 1));
    end
    for (int j = 0; j < nbits; j++) begin
      prog_v[k + j] = 1'b1;
      prog_b[k + j] = c[j];
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: bits arrive contiguously from cycle k of the collect phase. A gap of
  // TIMEOUT idle cycles (before or after the bits) ends collection with an error.
  function automatic void ref_model(input int k, input int nbits, input logic [CW-1:0] crc,
                                    output logic [CW-1:0] ec, output logic ee, output int lat);
    int got;
    got = (k >= TO) ? 0 : nbits;
    if (got >= CW) begin
      ec = crc; ee = 1'b0; lat = DW + CW + k + 2;
    end else begin
      ec = crc & CW'((1 << got) - 1);
      ee = 1'b1;
      lat = DW + 2 + TO + ((got == 0) ? 0 : k + got);
    end
  endfunction

  task automatic run_txn(input logic [DW-1:0] data, input int k, input int nbits,
                         input logic [CW-1:0] crc, input logic [CW-1:0] exp_crc,
                         input logic exp_err, input int exp_lat, input int hold,
                         input string tag);
    int waitc, lat, bad_ready;
    logic [DW-1:0] sh;
    program_stub(k, nbits, crc);
    waitc = 0;
    while (IN_Ready !== 1'b1 && waitc < 50) begin
      @(negedge CLK);
      waitc++;
    end
    check({tag, "_in_ready"}, 32'(IN_Ready), 32'd1);
    nclr = 0;
    nshift = 0;
    IN_Data = data;
    IN_Valid = 1'b1;
    @(negedge CLK);
    lat = 1;
    bad_ready = 0;
    while (OUT_Valid !== 1'b1 && lat < 100) begin
      if (IN_Ready !== 1'b0) bad_ready++;
      IN_Valid = 1'($urandom_range(0, 1));
      IN_Data = DW'($urandom);
      @(negedge CLK);
      lat++;
    end
    IN_Valid = 1'b0;
    for (int i = 0; i < DW; i++) sh[i] = shifted[i];
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_crc"}, 32'(OUT_CRC), 32'(exp_crc));
    check({tag, "_err"}, 32'(OUT_Err), 32'(exp_err));
    check({tag, "_clr_cycles"}, 32'(nclr), 32'd1);
    check({tag, "_shift_cycles"}, 32'(nshift), 32'(DW));
    check({tag, "_shift_bits"}, 32'(sh), 32'(data));
    check({tag, "_busy_ready"}, 32'(bad_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      IN_Valid = (i % 2 == 0);
      @(negedge CLK);
      check({tag, "_hold_valid"}, 32'(OUT_Valid), 32'd1);
      check({tag, "_hold_crc"}, {23'd0, OUT_Err, OUT_CRC}, {23'd0, exp_err, exp_crc});
      check({tag, "_hold_ready"}, 32'(IN_Ready), 32'd0);
    end
    IN_Valid = 1'b0;
    OUT_Ready = 1'b1;
    @(negedge CLK);
    OUT_Ready = 1'b0;
    check({tag, "_post_in_ready"}, 32'(IN_Ready), 32'd1);
    check({tag, "_post_out_valid"}, 32'(OUT_Valid), 32'd0);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            k;
    int            nbits;
    logic [CW-1:0] crc;
    logic [CW-1:0] exp_crc;
    logic          exp_err;
    int            exp_lat;
    int            hold;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [CW-1:0] ec;
    logic          ee;
    int            lat, nvalid, waitc;
    logic [DW-1:0] rd;
    logic [CW-1:0] rc;
    int            rk, rn;

    vecs[0] = '{8'hA5, 0, 8, 8'h3C, 8'h3C, 1'b0, 18, 0};
    vecs[1] = '{8'h5A, 0, 3, 8'h07, 8'h07, 1'b1, 29, 0};
    vecs[2] = '{8'hFF, 2, 8, 8'hC3, 8'hC3, 1'b0, 20, 5};
    vecs[3] = '{8'h00, 0, 8, 8'h11, 8'h11, 1'b0, 18, 0};
    vecs[4] = '{8'h81, 5, 8, 8'h5A, 8'h5A, 1'b0, 23, 0};
    vecs[5] = '{8'h00, 0, 0, 8'h00, 8'h00, 1'b1, 26, 0};
    vecs[6] = '{8'h3C, 1, 5, 8'hFF, 8'h1F, 1'b1, 32, 1};
    vecs[7] = '{8'h12, 0, 7, 8'hFE, 8'h7E, 1'b1, 33, 0};
    vecs[8] = '{8'h55, 15, 8, 8'hA5, 8'hA5, 1'b0, 33, 0};
    vecs[9] = '{8'h55, 16, 8, 8'hA5, 8'h00, 1'b1, 26, 2};

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_in_ready", 32'(IN_Ready), 32'd0);
      check("rst_out_valid", 32'(OUT_Valid), 32'd0);
      check("rst_core_rst_n", 32'(CRC_RST_n), 32'd0);
      check("rst_core_active", 32'(CRC_Active), 32'd0);
    end
    RST = 1'b0;
    @(negedge CLK);
    check("rel_in_ready", 32'(IN_Ready), 32'd1);
    check("rel_core_rst_n", 32'(CRC_RST_n), 32'd1);
    check("rel_out", {23'd0, OUT_Err, OUT_CRC}, 32'd0);

    foreach (vecs[i])
      run_txn(vecs[i].data, vecs[i].k, vecs[i].nbits, vecs[i].crc, vecs[i].exp_crc,
              vecs[i].exp_err, vecs[i].exp_lat, vecs[i].hold, $sformatf("vec%0d", i));

    // Reset during the 4th shift cycle aborts silently
    program_stub(0, 8, 8'hAA);
    waitc = 0;
    while (IN_Ready !== 1'b1 && waitc < 50) begin
      @(negedge CLK);
      waitc++;
    end
    IN_Data = 8'h5A;
    IN_Valid = 1'b1;
    @(negedge CLK);
    IN_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    check("abort_active_before", 32'(CRC_Active), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_core_rst_n", 32'(CRC_RST_n), 32'd0);
    check("abort_active", 32'(CRC_Active), 32'd0);
    check("abort_in_ready", 32'(IN_Ready), 32'd0);
    check("abort_out", {22'd0, OUT_Valid, OUT_Err, OUT_CRC}, 32'd0);
    RST = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (OUT_Valid !== 1'b0) nvalid++;
    end
    check("abort_no_result", 32'(nvalid), 32'd0);
    run_txn(8'hFF, 0, 8, 8'h96, 8'h96, 1'b0, 18, 0, "after_abort");

    // Randomized transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      rd = DW'($urandom);
      rc = CW'($urandom);
      rk = $urandom_range(0, 17);
      rn = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : 8;
      ref_model(rk, rn, rc, ec, ee, lat);
      run_txn(rd, rk, rn, rc, ec, ee, lat, $urandom_range(0, 2), $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
